// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating history
// counters. Lookup is combinational from registered state; training from
// the resolving stage lands on the next rising edge. Two saturating
// performance counters track accepted updates and mispredicts.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int CNT_W    = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [XLEN-1:0]     lookup_pc,
    output logic                hit,
    output logic                predict_taken,
    output logic [XLEN-1:0]     predict_target,
    input  logic                update_valid,
    input  logic [XLEN-1:0]     update_pc,
    input  logic                update_taken,
    input  logic [XLEN-1:0]     update_target,
    input  logic                update_mispredict,
    input  logic                flush_all,
    output logic [CNT_W-1:0]    perf_updates,
    output logic [CNT_W-1:0]    perf_mispredicts
);

    localparam int IDX = $clog2(ENTRIES);

    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

    // Table state.
    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    // Performance counters.
    logic [CNT_W-1:0] perf_upd_q, perf_upd_d;
    logic [CNT_W-1:0] perf_mis_q, perf_mis_d;

    // Address split: word index below, tag above it, byte offset ignored.
    logic [IDX-1:0]      lk_idx, upd_idx;
    logic [TAG_BITS-1:0] lk_tag, upd_tag;

    assign lk_idx  = lookup_pc[IDX+1:2];
    assign lk_tag  = lookup_pc[IDX+1+TAG_BITS:IDX+2];
    assign upd_idx = update_pc[IDX+1:2];
    assign upd_tag = update_pc[IDX+1+TAG_BITS:IDX+2];

    // The byte offset and the bits above the tag never take part.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc, update_pc};

    // Lookup path: purely combinational from the registered table, so a
    // same-cycle update to the same slot is seen only from the next cycle.
    logic lk_hit;
    assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign hit            = lk_hit;
    assign predict_taken  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
    assign predict_target = predict_taken ? target_q[lk_idx]
                                          : lookup_pc + XLEN'(4);

    // Training path: the resolving branch's current slot contents.
    logic                upd_hit;
    logic [CTR_BITS-1:0] upd_ctr_q, upd_ctr_d;

    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_ctr_q = ctr_q[upd_idx];

    // Saturating step of the history counter toward the actual outcome.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        upd_ctr_d = upd_ctr_q;
        if (update_taken) begin
            if (upd_ctr_q != CTR_MAX) upd_ctr_d = upd_ctr_q + CTR_BITS'(1);
        end else begin
            if (upd_ctr_q != '0) upd_ctr_d = upd_ctr_q - CTR_BITS'(1);
        end
    end

    // Table write: reset clears all, flush drops valids and wins over
    // training, otherwise hit-train or allocate-on-taken-miss.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            // NOTE: the table arrays are reset explicitly because a freshly
            // reset predictor must expose all-zero entries; this forces
            // flops rather than a RAM with no reset port.
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (flush_all) begin
            valid_q <= '0;
        end else if (update_valid) begin
            if (upd_hit) begin
                // NOTE: non-blocking writes keep every read in this cycle on
                // the pre-edge value, which gives the read-old behaviour.
                ctr_q[upd_idx] <= upd_ctr_d;
                if (update_taken) target_q[upd_idx] <= update_target;
            end else if (update_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= update_target;
                ctr_q[upd_idx]    <= CTR_WEAK;
            end
        end
    end

    // Next values of the saturating performance counters.
    always_comb begin
        perf_upd_d = perf_upd_q;
        perf_mis_d = perf_mis_q;
        if (update_valid) begin
            if (perf_upd_q != CNT_MAX) perf_upd_d = perf_upd_q + CNT_W'(1);
            if (update_mispredict && (perf_mis_q != CNT_MAX))
                perf_mis_d = perf_mis_q + CNT_W'(1);
        end
    end

    // Performance counter registers; a flush does not stop counting.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            perf_upd_q <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_upd_q <= perf_upd_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perf_updates     = perf_upd_q;
    assign perf_mispredicts = perf_mis_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor with a branch target buffer (BTB). It replaces static ID-stage branch resolution in the next-generation pipeline.
- Indexed by the IF-stage PC. It supplies a predicted-taken flag and target to the PC-select mux in the same cycle.
- The ID/EX stage that resolves the branch trains the table one or more cycles later.
- Saturating counters give per-entry history. A mispredict performance counter supports on-board debug.

Parameters:
XLEN, 32, address/data width
ENTRIES, 64, BTB entries; power of 2, >=4; IDX = log2(ENTRIES)
TAG_BITS, 8, stored tag width; TAG_BITS + IDX + 2 <= XLEN
CTR_BITS, 2, saturating history counter width, >=1
CNT_W, 16, performance counter width

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  active-low synchronous reset; sampled only on rising edge of Clk
lookup_pc  in  XLEN  IF-stage PC
hit  out  1  entry valid and tag match for lookup_pc
predict_taken  out  1  predicted taken
predict_target  out  XLEN  next PC prediction
update_valid  in  1  resolved branch training strobe
update_pc  in  XLEN  PC of resolved branch
update_taken  in  1  actual outcome
update_target  in  XLEN  actual taken target
update_mispredict  in  1  front end predicted wrongly (qualified by update_valid)
flush_all  in  1  invalidate whole table next edge
perf_updates  out  CNT_W  count of accepted updates
perf_mispredicts  out  CNT_W  count of accepted updates with update_mispredict=1

Behaviour:
- Address split:
  - idx = pc[IDX+1:2]
  - tag = pc[IDX+1+TAG_BITS:IDX+2]
  - pc[1:0] ignored.
- Entry contents: valid, tag, target[XLEN-1:0], ctr[CTR_BITS-1:0].
- Lookup is combinational from registered state, with zero-cycle latency.
  - hit = valid[idx] && tag match.
  - predict_taken = hit && ctr MSB.
  - predict_target = entry target if predict_taken, else lookup_pc + 4 (mod 2^XLEN).
- Lookup and update to the same index in the same cycle: the lookup returns pre-update contents. There is no write-through bypass.
- Update occurs on the rising edge when update_valid=1, Reset=1 and flush_all=0.
  - Hit with update_taken=1: ctr = min(ctr+1, 2^CTR_BITS-1); target = update_target.
  - Hit with update_taken=0: ctr = max(ctr-1, 0); target unchanged.
  - Miss with update_taken=1: allocate by overwriting the direct-mapped slot.
    - valid=1, tag=update tag, target=update_target.
    - ctr = weakly taken, i.e. 1 followed by CTR_BITS-1 zeros (2'b10).
  - Miss with update_taken=0: table unchanged; no allocation.
- Performance counters, on an accepted update (flush_all does not block counting):
  - perf_updates increments.
  - perf_mispredicts increments if update_mispredict=1.
  - Both saturate at all-ones; no wrap.
- flush_all=1: all valid bits clear at the next edge.
  - flush_all takes priority over a coincident update; the update's table effect is dropped.
  - tag, target and ctr contents are don't-care after a flush.
- Reset=0 at an edge:
  - All valid bits, tags, targets and counters clear to 0; perf counters clear to 0.
  - Any coincident update or flush is ignored.
  - Reset asserted mid-training leaves no partial entry.
- Output values out of reset, as functions of lookup_pc:
  - hit=0, predict_taken=0, predict_target=lookup_pc+4.
  - perf_updates=0, perf_mispredicts=0.
- No internal stall handling. The pipeline gates update_valid for squashed or stalled branches and must present each branch exactly once.
- Storage may be flops or distributed RAM, but must be read asynchronously and honour the read-old semantics above.

Test Plan:
1. Reset low one cycle, release; lookup_pc=0x00000040 -> hit=0, predict_taken=0, predict_target=0x00000044, perf_updates=0.
2. Update pc=0x40 taken, target 0x00000100 -> next cycle lookup 0x40 gives hit=1, predict_taken=1, predict_target=0x100, ctr=2, perf_updates=1.
3. Counter saturation from test 2 state:
   - Two not-taken updates on 0x40 (ctr 2->1->0) -> hit=1, predict_taken=0, target 0x44.
   - Four taken updates (ctr 1, 2, 3, 3) -> predict_taken=1; one not-taken update -> still taken (ctr=2).
4. Aliasing (same idx 0x10, tag 0x01 vs 0x00):
   - Lookup 0x00000140 -> hit=0.
   - Not-taken update of 0x140 -> 0x40 entry intact.
   - Taken update of 0x140, target 0x200 -> 0x140 hits with target 0x200; 0x40 misses.
5. Simultaneous events:
   - Taken update and lookup on 0x80 in the same cycle -> lookup shows hit=0; next cycle hit=1.
   - flush_all with taken update on 0xC0 -> next cycle all lookups miss; perf_updates still increments.
6. Counters and reset:
   - Update with update_mispredict=1 (CNT_W=4, 20 updates) -> perf_mispredicts saturates at 0xF.
   - Reset low with update_valid=1 -> next cycle all outputs at reset values, perf counters 0.
